bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Shares the two ports of a dual-port block RAM between NREQ requesters with round-robin arbitration, granting up to two requests per cycle (one per port). After reset it sequences a zero-clear of the whole memory before accepting traffic. It then routes 1-cycle-latency read data back to the requester that issued each read. It sits between task-queue/PE-side clients and the `DualPortBRAM` instance; it drives the RAM ports directly.

## Interface
Parameters:
- DATA, 72, RAM word width
- ADDR, 10, RAM address width (≥1); depth 2**ADDR
- NREQ, 4, number of requesters (2..16)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; handshake when valid & ready
- req_wr  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR  packed addresses; requester i uses slice i
- req_din  in  NREQ*DATA  packed write data
- resp_valid  out  NREQ  read data valid, 1-cycle pulse
- resp_data  out  NREQ*DATA  packed read data; slice i is valid when resp_valid[i]
- init_done  out  1  memory clear finished
- a_wr, a_addr, a_din  out  1/ADDR/DATA  RAM port A controls
- a_dout  in  DATA  RAM port A read data
- b_wr, b_addr, b_din  out  1/ADDR/DATA  RAM port B controls
- b_dout  in  DATA  RAM port B read data

## Operation
- FSM states: S_RST (reset value), S_INIT, S_RUN.
  - S_RST → S_INIT unconditionally on the first clock after reset release.
  - S_INIT → S_RUN after the last clear cycle.
  - S_RUN is terminal.
- S_RST: all RAM write enables 0; all req_ready 0.
- S_INIT: clear counter k runs 0..2**(ADDR-1)-1.
  - Port A writes address 2k with 0; port B writes address 2k+1 with 0.
  - req_ready stays 0.
  - After k = max, the FSM enters S_RUN and init_done is set.
- S_RUN arbitration, combinational from req_valid and the round-robin pointer ptr:
  - Port A candidate: first valid requester at or after ptr, in circular order.
  - Port B candidate: the next valid requester after the A candidate, excluding the A candidate.
  - req_ready[i] = 1 only for granted requesters. ready is 0 for non-valid requesters.
- Granted requests drive the RAM port directly in the same cycle: wr, addr, din.
  - Ungranted port: wr = 0, addr = 0, din = 0.
- ptr update:
  - ptr ← (index of last granted requester + 1) mod NREQ; B if granted, else A.
  - ptr is unchanged when nothing is granted.
  - ptr resets to 0.
- Read tracking: each port has a registered tag {valid, requester index}, captured when a read is granted.
  - Next cycle, resp_valid[tag] = 1 and resp_data slice = that port's dout.
  - Both ports may respond in the same cycle to different requesters.
  - Writes produce no response.
- Responses have no backpressure; requesters must accept.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_data 0, init_done 0, a_wr/b_wr 0, addresses 0, ptr 0, FSM S_RST, tags invalid.
- Clear duration: S_RST 1 cycle + 2**(ADDR-1) cycles.
  - First req_ready can be asserted in the cycle after init_done rises.
- Read latency: handshake in cycle T → resp_valid in T+1.
- Write latency: handshake in T → RAM updated at the end of T; a read of the same address granted in T+1 returns the new data.
- Simultaneous read and write to the same address on different ports: governed by Configuration.
- Reset mid-operation: reset is asynchronous and clears everything, including pending tags; in-flight responses are dropped. The clear sequence reruns.
- A requester keeps valid, wr, addr and din stable until ready.

## Configuration
- BRAM_ARB_COLLISION_CHECK_EN
  - Defined: if the A and B candidates have equal addresses and either is a write, port B is not granted that cycle. ptr then advances past A only, and the B candidate retries next cycle.
  - Undefined: no address comparison; both are granted. Same-address collisions are undefined and must be excluded by the requesters.

## Test plan
- Reset, ADDR=4 → init_done rises 9 cycles after release; then read every address from each requester → all resp_data = 0.
- NREQ=4, all valid reads at addresses 1..4, ptr=0 → grants {0,1}, then {2,3}, then {0,1}; each resp_valid arrives exactly 1 cycle after its handshake.
- Requester 2 writes 0x5A to addr 7 in cycle T; requester 3 reads addr 7 in T+1 → resp_data[3] = 0x5A in T+2.
- With BRAM_ARB_COLLISION_CHECK_EN: requester 0 writes addr 3 and requester 1 reads addr 3 in the same cycle → only 0 granted; 1 granted next cycle, reads the new value.
- Single requester 1 holding valid continuously → granted on port A every cycle; ptr stays 2.
- Reset asserted the cycle after a read grant → no resp_valid; the clear sequence restarts and init_done = 0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port BRAM among NREQ requesters, with a post-reset zero-clear.
// Optional macro BRAM_ARB_COLLISION_CHECK_EN withholds port B on a same-address conflict involving a write.
module bram_port_arbiter #(
  parameter int DATA = 72,
  parameter int ADDR = 10,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*DATA-1:0] req_din,
  output logic [NREQ-1:0]      resp_valid,
  output logic [NREQ*DATA-1:0] resp_data,
  output logic                 init_done,
  output logic                 a_wr,
  output logic [ADDR-1:0]      a_addr,
  output logic [DATA-1:0]      a_din,
  input  logic [DATA-1:0]      a_dout,
  output logic                 b_wr,
  output logic [ADDR-1:0]      b_addr,
  output logic [DATA-1:0]      b_din,
  input  logic [DATA-1:0]      b_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);
  localparam int unsigned K_MAX_I = (1 << (ADDR-1)) - 1;
  localparam logic [ADDR-1:0] K_MAX = ADDR'(K_MAX_I);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t          state_r;
  logic [ADDR-1:0] clr_k_r;
  logic            init_done_r;
  logic [IW-1:0]   ptr_r;
  logic            tag_a_v_r;
  logic            tag_b_v_r;
  logic [IW-1:0]   tag_a_idx_r;
  logic [IW-1:0]   tag_b_idx_r;

  logic            a_found_s;
  logic            b_found_s;
  logic [IW-1:0]   a_idx_s;
  logic [IW-1:0]   b_idx_s;
  logic [IW-1:0]   cand_s;
  logic            a_sel_wr_s;
  logic            b_sel_wr_s;
  logic [ADDR-1:0] a_sel_addr_s;
  logic [ADDR-1:0] b_sel_addr_s;
  logic [DATA-1:0] a_sel_din_s;
  logic [DATA-1:0] b_sel_din_s;
  logic            collide_s;
  logic            run_s;
  logic            a_grant_s;
  logic            b_grant_s;

  // Circular (base + off) mod NREQ, with off < NREQ
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input logic [IW-1:0] off);
    logic [IW:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= NREQ_W) begin
      s = s - NREQ_W;
    end else begin
      s = s;
    end
    return s[IW-1:0];
  endfunction

  // Round-robin search: A is the first valid at/after ptr, B the next valid after A
  always_comb begin
    a_found_s = 1'b0;
    a_idx_s   = '0;
    b_found_s = 1'b0;
    b_idx_s   = '0;
    cand_s    = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand_s = wrap_add(ptr_r, IW'(j));
      if (!a_found_s && req_valid[cand_s]) begin
        a_found_s = 1'b1;
        a_idx_s   = cand_s;
      end else begin
        a_found_s = a_found_s;
      end
    end
    for (int j = 1; j < NREQ; j++) begin
      cand_s = wrap_add(a_idx_s, IW'(j));
      if (a_found_s && !b_found_s && req_valid[cand_s]) begin
        b_found_s = 1'b1;
        b_idx_s   = cand_s;
      end else begin
        b_found_s = b_found_s;
      end
    end
  end

  assign a_sel_wr_s   = req_wr[a_idx_s];
  assign b_sel_wr_s   = req_wr[b_idx_s];
  assign a_sel_addr_s = req_addr[a_idx_s*ADDR +: ADDR];
  assign b_sel_addr_s = req_addr[b_idx_s*ADDR +: ADDR];
  assign a_sel_din_s  = req_din[a_idx_s*DATA +: DATA];
  assign b_sel_din_s  = req_din[b_idx_s*DATA +: DATA];

`ifdef BRAM_ARB_COLLISION_CHECK_EN
  assign collide_s = a_found_s & b_found_s & (a_sel_addr_s == b_sel_addr_s) & (a_sel_wr_s | b_sel_wr_s);
`else
  assign collide_s = 1'b0;
`endif

  assign run_s     = (state_r == S_RUN);
  assign a_grant_s = run_s & a_found_s;
  assign b_grant_s = run_s & b_found_s & ~collide_s;
  assign init_done = init_done_r;

  // RAM port drive and per-requester ready
  always_comb begin
    a_wr      = 1'b0;
    a_addr    = '0;
    a_din     = '0;
    b_wr      = 1'b0;
    b_addr    = '0;
    b_din     = '0;
    req_ready = '0;
    case (state_r)
      S_INIT: begin
        a_wr   = 1'b1;
        a_addr = clr_k_r << 1;
        b_wr   = 1'b1;
        b_addr = (clr_k_r << 1) | ADDR'(1);
      end
      S_RUN: begin
        if (a_grant_s) begin
          a_wr               = a_sel_wr_s;
          a_addr             = a_sel_addr_s;
          a_din              = a_sel_din_s;
          req_ready[a_idx_s] = 1'b1;
        end else begin
          a_wr = 1'b0;
        end
        if (b_grant_s) begin
          b_wr               = b_sel_wr_s;
          b_addr             = b_sel_addr_s;
          b_din              = b_sel_din_s;
          req_ready[b_idx_s] = 1'b1;
        end else begin
          b_wr = 1'b0;
        end
      end
      default: begin
        a_wr = 1'b0;
        b_wr = 1'b0;
      end
    endcase
  end

  // Route last cycle's read data back to the issuing requester
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (tag_a_v_r) begin
      resp_valid[tag_a_idx_r]               = 1'b1;
      resp_data[tag_a_idx_r*DATA +: DATA]   = a_dout;
    end else begin
      resp_valid = resp_valid;
    end
    if (tag_b_v_r) begin
      resp_valid[tag_b_idx_r]               = 1'b1;
      resp_data[tag_b_idx_r*DATA +: DATA]   = b_dout;
    end else begin
      resp_valid = resp_valid;
    end
  end

  // Sequencer: clear counter, round-robin pointer and read tags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_RST;
      clr_k_r     <= '0;
      init_done_r <= 1'b0;
      ptr_r       <= '0;
      tag_a_v_r   <= 1'b0;
      tag_b_v_r   <= 1'b0;
      tag_a_idx_r <= '0;
      tag_b_idx_r <= '0;
    end else begin
      case (state_r)
        S_RST: begin
          state_r   <= S_INIT;
          clr_k_r   <= '0;
          tag_a_v_r <= 1'b0;
          tag_b_v_r <= 1'b0;
        end
        S_INIT: begin
          if (clr_k_r == K_MAX) begin
            state_r     <= S_RUN;
            init_done_r <= 1'b1;
          end else begin
            clr_k_r <= clr_k_r + ADDR'(1);
          end
        end
        S_RUN: begin
          if (b_grant_s) begin
            ptr_r <= wrap_add(b_idx_s, IW'(1));
          end else if (a_grant_s) begin
            ptr_r <= wrap_add(a_idx_s, IW'(1));
          end else begin
            ptr_r <= ptr_r;
          end
          tag_a_v_r   <= a_grant_s & ~a_sel_wr_s;
          tag_a_idx_r <= a_idx_s;
          tag_b_v_r   <= b_grant_s & ~b_sel_wr_s;
          tag_b_idx_r <= b_idx_s;
        end
        default: begin
          state_r <= S_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a behavioural dual-port RAM (ADDR=4, NREQ=4).
module tb_bram_port_arbiter;
  localparam int DATA = 16;
  localparam int ADDR = 4;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_wr;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*DATA-1:0] req_din;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ*DATA-1:0] resp_data;
  logic                 init_done;
  logic                 a_wr, b_wr;
  logic [ADDR-1:0]      a_addr, b_addr;
  logic [DATA-1:0]      a_din, b_din, a_dout, b_dout;
  logic [DATA-1:0]      mem [2**ADDR];
  int                   n_cmp = 0;
  int                   n_err = 0;

  bram_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_din(req_din),
    .resp_valid(resp_valid), .resp_data(resp_data), .init_done(init_done),
    .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
    .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with 1-cycle registered read
  always @(posedge clk) begin
    if (a_wr) mem[a_addr] <= a_din;
    if (b_wr) mem[b_addr] <= b_din;
    a_dout <= mem[a_addr];
    b_dout <= mem[b_addr];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_din   = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [ADDR-1:0] ad, input logic [DATA-1:0] d);
    req_valid[i]             = v;
    req_wr[i]                = w;
    req_addr[i*ADDR +: ADDR] = ad;
    req_din[i*DATA +: DATA]  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA-1:0] slice(input int i);
    return resp_data[i*DATA +: DATA];
  endfunction

  // Release reset (rst must be low on entry) and walk the clear sequence
  task automatic run_init();
    clr_req();
    set_req(0, 1'b1, 1'b0, 4'd0, 16'h0);
    repeat (2) @(posedge clk);
    #3;
    check_val("rst_ready", {60'd0, req_ready}, 64'd0);
    check_val("rst_init_done", {63'd0, init_done}, 64'd0);
    check_val("rst_a_wr", {63'd0, a_wr}, 64'd0);
    rst = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        check_val("init_k0_a", {59'd0, a_wr, a_addr}, {59'd0, 1'b1, 4'd0});
        check_val("init_k0_b", {59'd0, b_wr, b_addr}, {59'd0, 1'b1, 4'd1});
      end
      if (c == 4) begin
        check_val("init_ready", {60'd0, req_ready}, 64'd0);
        clr_req();
      end
      if (c == 8) begin
        check_val("init_k7_addrs", {56'd0, a_addr, b_addr}, {56'd0, 4'd14, 4'd15});
        check_val("init_done_c8", {63'd0, init_done}, 64'd0);
      end
      if (c == 9) check_val("init_done_c9", {63'd0, init_done}, 64'd1);
    end
  endtask

  initial begin
    clr_req();
    for (int i = 0; i < 2**ADDR; i++) mem[i] = 16'hA000 + 16'(i);
    run_init();

    // Every address reads zero from every requester
    for (int r = 0; r < NREQ; r++) begin
      for (int ad = 0; ad < 2**ADDR; ad++) begin
        clr_req();
        set_req(r, 1'b1, 1'b0, 4'(ad), 16'h0);
        #1;
        check_val("clr_ready", {60'd0, req_ready}, 64'd1 << r);
        step();
        clr_req();
        check_val("clr_resp_valid", {60'd0, resp_valid}, 64'd1 << r);
        check_val("clr_resp_data", {48'd0, slice(r)}, 64'd0);
      end
    end

    // Seed addresses 1..4 through requester 3 (pointer returns to 0)
    for (int i = 0; i < 4; i++) begin
      clr_req();
      set_req(3, 1'b1, 1'b1, 4'(i + 1), 16'h100 + 16'(i));
      #1;
      check_val("seed_ready", {60'd0, req_ready}, 64'h8);
      step();
    end
    clr_req();

    // All four requesters reading continuously
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 4'(i + 1), 16'h0);
    #1;
    check_val("rr1_ready", {60'd0, req_ready}, 64'h3);
    check_val("rr1_addrs", {56'd0, a_addr, b_addr}, {56'd0, 4'd1, 4'd2});
    step();
    check_val("rr1_resp", {60'd0, resp_valid}, 64'h3);
    check_val("rr1_d0", {48'd0, slice(0)}, 64'h100);
    check_val("rr1_d1", {48'd0, slice(1)}, 64'h101);
    check_val("rr2_ready", {60'd0, req_ready}, 64'hC);
    step();
    check_val("rr2_resp", {60'd0, resp_valid}, 64'hC);
    check_val("rr2_d2", {48'd0, slice(2)}, 64'h102);
    check_val("rr2_d3", {48'd0, slice(3)}, 64'h103);
    check_val("rr3_ready", {60'd0, req_ready}, 64'h3);
    step();
    check_val("rr3_resp", {60'd0, resp_valid}, 64'h3);
    clr_req();

    // Write then read-after-write from another requester
    set_req(2, 1'b1, 1'b1, 4'd7, 16'h5A);
    #1;
    check_val("wr7_ready", {60'd0, req_ready}, 64'h4);
    step();
    clr_req();
    set_req(3, 1'b1, 1'b0, 4'd7, 16'h0);
    #1;
    check_val("wr7_no_resp", {60'd0, resp_valid}, 64'd0);
    check_val("rd7_ready", {60'd0, req_ready}, 64'h8);
    step();
    clr_req();
    check_val("rd7_resp", {60'd0, resp_valid}, 64'h8);
    check_val("rd7_data", {48'd0, slice(3)}, 64'h5A);

    // Lone requester 1 holds valid: port A every cycle, B idle
    set_req(1, 1'b1, 1'b0, 4'd5, 16'h0);
    #1;
    for (int c = 0; c < 3; c++) begin
      check_val("solo_ready", {60'd0, req_ready}, 64'h2);
      check_val("solo_a", {59'd0, a_wr, a_addr}, {59'd0, 1'b0, 4'd5});
      check_val("solo_b", {59'd0, b_wr, b_addr}, 64'd0);
      step();
    end
    clr_req();
    // Pointer now 2: requester 2 wins A ahead of requester 0
    set_req(0, 1'b1, 1'b0, 4'd9, 16'h0);
    set_req(2, 1'b1, 1'b0, 4'd11, 16'h0);
    #1;
    check_val("ptr2_addrs", {56'd0, a_addr, b_addr}, {56'd0, 4'd11, 4'd9});
    step();
    clr_req();
    check_val("ptr2_resp", {60'd0, resp_valid}, 64'h5);

    // Requester 3 write moves pointer to 0
    set_req(3, 1'b1, 1'b1, 4'd12, 16'h33);
    step();
    clr_req();

    // Same-address write (A) and read (B)
    set_req(0, 1'b1, 1'b1, 4'd3, 16'h77);
    set_req(1, 1'b1, 1'b0, 4'd3, 16'h0);
    #1;
`ifdef BRAM_ARB_COLLISION_CHECK_EN
    check_val("coll_ready1", {60'd0, req_ready}, 64'h1);
    step();
    set_req(0, 1'b0, 1'b0, 4'd0, 16'h0);
    #1;
    check_val("coll_ready2", {60'd0, req_ready}, 64'h2);
    step();
    clr_req();
    check_val("coll_resp", {60'd0, resp_valid}, 64'h2);
    check_val("coll_data", {48'd0, slice(1)}, 64'h77);
`else
    check_val("nocoll_ready", {60'd0, req_ready}, 64'h3);
    step();
    clr_req();
    check_val("nocoll_resp", {60'd0, resp_valid}, 64'h2);
`endif

    // Reset right after a read grant drops the response
    set_req(0, 1'b1, 1'b0, 4'd2, 16'h0);
    #1;
    check_val("mid_ready", {60'd0, req_ready}, 64'h1);
    step();
    rst = 1'b0;
    #1;
    check_val("mid_resp", {60'd0, resp_valid}, 64'd0);
    check_val("mid_init_done", {63'd0, init_done}, 64'd0);
    check_val("mid_ready_rst", {60'd0, req_ready}, 64'd0);
    run_init();

    // Address 7 cleared again by the rerun
    set_req(3, 1'b1, 1'b0, 4'd7, 16'h0);
    #1;
    check_val("post_ready", {60'd0, req_ready}, 64'h8);
    step();
    clr_req();
    check_val("post_resp", {60'd0, resp_valid}, 64'h8);
    check_val("post_data", {48'd0, slice(3)}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
